aurora_rx_block_decoder: RTL

AURORA_RX_BLOCK_DECODER -- requirements
Module: aurora_rx_block_decoder

---
 rtl/aurora_rx_block_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aurora_rx_block_decoder.sv
// Aurora 64B/66B receive block decoder: header lock FSM, block classification and output FIFO.
// Optional macro AURORA_RX_DEC_STATS_EN enables the saturating err_cnt_o counter (tied to zero otherwise).
module aurora_rx_block_decoder #(
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_CNT = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_rx_i,
    input  logic        rst_n_i,
    input  logic [63:0] rx_data_i,
    input  logic [1:0]  rx_header_i,
    input  logic        rx_valid_i,
    output logic [63:0] out_data_o,
    output logic        out_kword_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        locked_o,
    output logic        overflow_o,
    output logic [15:0] err_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LOCK_CNT_W   = 8'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_CNT_W = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_LOST   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_good_cnt, w_good_cnt_nxt;
    logic [3:0] r_bad_cnt, w_bad_cnt_nxt;

    logic [7:0] w_type;
    logic       w_hdr_ok;
    logic       w_is_ctrl;
    logic       w_type_userk;
    logic       w_push_req;

    assign w_type       = rx_data_i[63:56];
    assign w_hdr_ok     = (rx_header_i == 2'b01) || (rx_header_i == 2'b10);
    assign w_is_ctrl    = (rx_header_i == 2'b10);
    assign w_type_userk = w_is_ctrl && (w_type inside {8'hD2, 8'h99, 8'h55, 8'hB4, 8'hCC});
    // Lock is judged on the registered state, so the block that completes lock is not forwarded.
    assign w_push_req   = rx_valid_i && (r_state == ST_LOCKED) &&
                          ((rx_header_i == 2'b01) || w_type_userk);

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_LOST;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
            r_bad_cnt  <= w_bad_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        if (rx_valid_i) begin
            case (r_state)
                ST_LOST: begin
                    if (w_hdr_ok) begin
                        w_state_nxt    = ST_HUNT;
                        w_good_cnt_nxt = 8'd1;
                    end
                end
                ST_HUNT: begin
                    if (w_hdr_ok) begin
                        w_good_cnt_nxt = r_good_cnt + 8'd1;
                        if (r_good_cnt + 8'd1 == LOCK_CNT_W) begin
                            w_state_nxt   = ST_LOCKED;
                            w_bad_cnt_nxt = '0;
                        end
                    end else begin
                        w_state_nxt    = ST_LOST;
                        w_good_cnt_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_hdr_ok) begin
                        w_bad_cnt_nxt = '0;
                    end else if (r_bad_cnt + 4'd1 == UNLOCK_CNT_W) begin
                        w_state_nxt    = ST_LOST;
                        w_good_cnt_nxt = '0;
                        w_bad_cnt_nxt  = '0;
                    end else begin
                        w_bad_cnt_nxt = r_bad_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_LOST;
                    w_good_cnt_nxt = '0;
                    w_bad_cnt_nxt  = '0;
                end
            endcase
        end
    end

    assign locked_o = (r_state == ST_LOCKED);

    // Output FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [64:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_overflow;
    logic        w_empty, w_full, w_pop, w_push, w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready_i;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_rx_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_type_userk, rx_data_i};
    end

    assign out_valid_o = !w_empty;
    assign out_data_o  = w_empty ? 64'd0 : r_mem[r_rd_ptr[AW-1:0]][63:0];
    assign out_kword_o = w_empty ? 1'b0  : r_mem[r_rd_ptr[AW-1:0]][64];
    assign overflow_o  = r_overflow;

`ifdef AURORA_RX_DEC_STATS_EN
    logic [15:0] r_err_cnt;
    logic        w_err_inc;

    // Unknown control types are errors but still count as good headers for lock.
    assign w_err_inc = rx_valid_i &&
                       (!w_hdr_ok || (w_is_ctrl && (w_type != 8'h78) && !w_type_userk));

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule
